// File: rtl/dwpe_feeder.sv
// dwpe_feeder
//   Producer side of the depthwise PE input interface. Buffers a 3-row input
//   tile (POX+2 pixels per row) plus the 9 kernel weights, then replays the
//   tile as 9 shifted taps (pixel_array + weight with dwpe_ena). Each tap is
//   issued on an edge where out_ready is high, so the downstream MAC bank
//   builds one 3x3 stride-1 output row of POX pixels.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   frame_start       pulse; the next tile needs a full 3-row load
//   w_wr_en/addr/data weight write port, addr = ky*3+kx (0..8)
//   row_valid/ready   row handshake, row_data[j] = column j
//   out_ready         downstream may take a tap on this edge
//   dwpe_ena          tap valid
//   pixel_array       POX tap pixels
//   weight            tap weight
//   tile_last         high with the 9th tap of a tile
//   busy              tile is being issued (weight writes ignored)
//
// Configuration macro
//   DWF_ROW_REUSE_EN  when defined, after the first full tile each LOAD needs
//                     only one new row; rows slide through a mod-3 base
//                     pointer instead of being shifted.
module dwpe_feeder #(
  parameter int DW  = 32,
  parameter int POX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          w_wr_en,
  input  logic [3:0]    w_wr_addr,
  input  logic [DW-1:0] w_wr_data,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [DW-1:0] row_data [POX+2],
  input  logic          out_ready,
  output logic          dwpe_ena,
  output logic [DW-1:0] pixel_array [POX],
  output logic [DW-1:0] weight,
  output logic          tile_last,
  output logic          busy
);

  typedef enum logic {LOAD, ISSUE} state_t;

  state_t        state, state_d;
  logic [1:0]    row_cnt;
  logic [3:0]    tap_cnt;
  logic          xfer, load_done, tap_go, tap_done;
  logic [1:0]    wr_idx, wr_slot, rd_slot;
  logic [1:0]    ky, kx;
  logic [DW-1:0] row_mem [3][POX+2];
  logic [DW-1:0] w_mem   [9];
  logic [DW-1:0] sel_row [POX+2];
  logic [DW-1:0] sel_w;

  assign row_ready = (state == LOAD) && !rst;
  assign busy      = (state == ISSUE) && !rst;
  assign xfer      = row_valid && row_ready;
  // frame_start coinciding with a row makes that row the first of the tile
  assign wr_idx    = frame_start ? 2'd0 : row_cnt;
  assign tap_go    = (state == ISSUE) && out_ready;
  assign tap_done  = tap_go && (tap_cnt == 4'd8);

`ifdef DWF_ROW_REUSE_EN
  logic [1:0] base;
  logic       primed;
  logic       single;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // One new row suffices once a full tile has been seen since reset/frame_start
  assign single    = primed && !frame_start;
  assign load_done = xfer && (single || (wr_idx == 2'd2));
  // The new row overwrites the oldest slot; advancing base slides the window
  assign wr_slot   = mod3_add(base, wr_idx);
  assign rd_slot   = mod3_add(base, ky);

  always_ff @(posedge clk) begin
    if (rst) begin
      base   <= 2'd0;
      primed <= 1'b0;
    end else begin
      if (frame_start)
        primed <= 1'b0;
      else if (load_done)
        primed <= 1'b1;
      if (load_done && single)
        base <= mod3_add(base, 2'd1);
    end
  end
`else
  assign load_done = xfer && (wr_idx == 2'd2);
  assign wr_slot   = wr_idx;
  assign rd_slot   = ky;
`endif

  always_comb begin
    ky = 2'd0;
    kx = 2'd0;
    case (tap_cnt)
      4'd1: kx = 2'd1;
      4'd2: kx = 2'd2;
      4'd3: ky = 2'd1;
      4'd4: begin ky = 2'd1; kx = 2'd1; end
      4'd5: begin ky = 2'd1; kx = 2'd2; end
      4'd6: ky = 2'd2;
      4'd7: begin ky = 2'd2; kx = 2'd1; end
      4'd8: begin ky = 2'd2; kx = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    sel_row = row_mem[0];
    if (rd_slot == 2'd1)
      sel_row = row_mem[1];
    else if (rd_slot == 2'd2)
      sel_row = row_mem[2];
  end

  always_comb begin
    sel_w = '0;
    for (int k = 0; k < 9; k++)
      if (tap_cnt == 4'(k))
        sel_w = w_mem[k];
  end

  always_comb begin
    state_d = state;
    case (state)
      LOAD:    if (load_done) state_d = ISSUE;
      ISSUE:   if (tap_done)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= LOAD;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= 2'd0;
      tap_cnt <= 4'd0;
    end else begin
      if (state == LOAD) begin
        if (load_done)
          row_cnt <= 2'd0;
        else if (xfer)
          row_cnt <= wr_idx + 2'd1;
        else if (frame_start)
          row_cnt <= 2'd0;
      end
      if (load_done)
        tap_cnt <= 4'd0;
      else if (tap_go)
        tap_cnt <= tap_done ? 4'd0 : tap_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++)
        w_mem[k] <= '0;
    end else if (w_wr_en && !busy) begin
      for (int k = 0; k < 9; k++)
        if (w_wr_addr == 4'(k))
          w_mem[k] <= w_wr_data;
    end
  end

  // Row storage carries no reset; it is always fully written before use
  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++)
      if (xfer && (wr_slot == 2'(r)))
        row_mem[r] <= row_data;
  end

  // Tap output register: loads on accepted taps, holds data otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      dwpe_ena  <= 1'b0;
      tile_last <= 1'b0;
      weight    <= '0;
      for (int i = 0; i < POX; i++)
        pixel_array[i] <= '0;
    end else begin
      dwpe_ena  <= tap_go;
      tile_last <= tap_done;
      if (tap_go) begin
        weight <= sel_w;
        for (int i = 0; i < POX; i++) begin
          case (kx)
            2'd1:    pixel_array[i] <= sel_row[i+1];
            2'd2:    pixel_array[i] <= sel_row[i+2];
            default: pixel_array[i] <= sel_row[i];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dwpe_feeder.sv
module tb_dwpe_feeder;
  localparam int DW  = 32;
  localparam int POX = 4;
  localparam int RW  = POX + 2;
`ifdef DWF_ROW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef logic [DW-1:0] row_t [RW];
  typedef struct {
    logic [DW-1:0] pix [POX];
    logic [DW-1:0] w;
    logic          last;
  } tap_t;

  logic          clk = 1'b0;
  logic          rst, frame_start, w_wr_en, row_valid, row_ready, out_ready;
  logic [3:0]    w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic [DW-1:0] row_data [RW];
  logic          dwpe_ena, tile_last, busy;
  logic [DW-1:0] pixel_array [POX];
  logic [DW-1:0] weight;

  int   checks = 0;
  int   failures = 0;
  int   taps_seen = 0;
  int   or_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
  logic or_at_edge = 1'b0;

  // reference model state
  tap_t          exp_q [$];
  tap_t          mon_e;
  logic [DW-1:0] mw [9];
  row_t          win [3];
  row_t          pend [3];
  int            pend_n;
  bit            primed;

  dwpe_feeder #(.DW(DW), .POX(POX)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .out_ready(out_ready), .dwpe_ena(dwpe_ena), .pixel_array(pixel_array),
    .weight(weight), .tile_last(tile_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) mw[k] = '0;
    pend_n = 0;
    primed = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_fs();
    pend_n = 0;
    primed = 1'b0;
  endtask

  // A tile completes once enough rows are gathered; its 9 taps are the
  // 3x3 window offsets applied to the current 3-row window.
  task automatic model_row(input row_t r);
    int   need;
    tap_t e;
    need = (REUSE && primed) ? 1 : 3;
    pend[pend_n] = r;
    pend_n++;
    if (pend_n == need) begin
      if (need == 3) begin
        for (int k = 0; k < 3; k++) win[k] = pend[k];
      end else begin
        win[0] = win[1];
        win[1] = win[2];
        win[2] = pend[0];
      end
      pend_n = 0;
      primed = REUSE;
      for (int t = 0; t < 9; t++) begin
        for (int i = 0; i < POX; i++) e.pix[i] = win[t / 3][i + t % 3];
        e.w    = mw[t];
        e.last = (t == 8);
        exp_q.push_back(e);
      end
    end
  endtask

  // out_ready driver, changes on the falling edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = 1'b0;
        2:       out_ready = ~out_ready;
        3:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(posedge clk) or_at_edge <= out_ready;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (dwpe_ena) begin
      taps_seen++;
      check("ena_after_ready", 64'(or_at_edge), 64'd1);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tap actual=dwpe_ena_1 required=no_tap_pending");
      end else begin
        int bad;
        mon_e = exp_q.pop_front();
        bad = -1;
        for (int i = 0; i < POX; i++)
          if (bad < 0 && pixel_array[i] !== mon_e.pix[i]) bad = i;
        if (bad >= 0) begin
          failures++;
          $display("FAIL tap_pixel[%0d] actual=%0h required=%0h", bad,
                   pixel_array[bad], mon_e.pix[bad]);
        end
        check("tap_weight", 64'(weight), 64'(mon_e.w));
        check("tap_last", 64'(tile_last), 64'(mon_e.last));
      end
    end
  end

  task automatic send_row(input row_t r, input bit fs);
    bit done;
    done = 1'b0;
    row_data    = r;
    row_valid   = 1'b1;
    frame_start = fs;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (row_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
    end
    row_valid   = 1'b0;
    frame_start = 1'b0;
    if (done) begin
      if (fs) model_fs();
      model_row(r);
    end else begin
      checks++;
      failures++;
      $display("FAIL row_handshake actual=timeout required=row_ready");
    end
  endtask

  task automatic rand_row(input bit fs);
    row_t r;
    for (int j = 0; j < RW; j++) r[j] = $urandom;
    send_row(r, fs);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    model_fs();
  endtask

  task automatic write_w(input int addr, input logic [DW-1:0] data, input bit dut_busy);
    w_wr_en   = 1'b1;
    w_wr_addr = 4'(addr);
    w_wr_data = data;
    @(posedge clk);
    #1;
    w_wr_en = 1'b0;
    if (addr < 9 && !dut_busy) mw[addr] = data;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 800; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s actual=%0d_taps_outstanding required=0", name, exp_q.size());
      exp_q.delete();
    end
    idle(1);
  endtask

  initial begin
    row_t       r;
    logic [10:0] pat;
    int         t0;
    int         act;
    rst = 1'b1; frame_start = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0;
    w_wr_data = '0; row_valid = 1'b0;
    for (int j = 0; j < RW; j++) row_data[j] = '0;
    model_reset();

    // reset state
    @(posedge clk);
    #1;
    check("rst_ena", 64'(dwpe_ena), 64'd0);
    check("rst_last", 64'(tile_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_row_ready", 64'(row_ready), 64'd0);
    check("rst_weight", 64'(weight), 64'd0);
    begin
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < POX; i++) acc = acc | pixel_array[i];
      check("rst_pixels", 64'(acc), 64'd0);
    end
    idle(1);
    rst = 1'b0;
    #1;
    check("post_rst_row_ready", 64'(row_ready), 64'd1);

    // directed tile: w[t]=t+1, row[r][j]=10r+j, out_ready held high
    for (int t = 0; t < 9; t++) write_w(t, DW'(t + 1), 1'b0);
    for (int rr = 0; rr < 3; rr++) begin
      for (int j = 0; j < RW; j++) r[j] = DW'(10 * rr + j);
      send_row(r, 1'b0);
    end
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      pat[k] = dwpe_ena;
    end
    check("ena_burst", 64'(pat), 64'(11'b01111111110));
    @(posedge clk);
    #1;
    drain("tile_directed");

    // alternating out_ready
    or_mode = 2;
    for (int k = 0; k < 3; k++) rand_row(1'b0);
    drain("tile_toggle");
    or_mode = 1;

    // ignored weight writes: bad address, then while busy
    write_w(9, 77, 1'b0);
    or_mode = 0;
    idle(1);
    for (int k = 0; k < 3; k++) rand_row(1'b0);
    idle(2);
    check("stalled_busy", 64'(busy), 64'd1);
    check("stalled_ena", 64'(dwpe_ena), 64'd0);
    write_w(0, 55, 1'b1);
    or_mode = 1;
    drain("tile_stalled");
    for (int k = 0; k < 3; k++) rand_row(1'b0);
    drain("tile_after_ignored_writes");

    // reset during the 6th tap
    t0 = taps_seen;
    for (int k = 0; k < 3; k++) rand_row(1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (taps_seen - t0 >= 5) break;
    end
    check("reset_wait_taps", 64'(taps_seen - t0 >= 5), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("midrst_ena", 64'(dwpe_ena), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_row_ready", 64'(row_ready), 64'd0);
    check("midrst_last", 64'(tile_last), 64'd0);
    idle(1);
    rst = 1'b0;
    rand_row(1'b0);
    rand_row(1'b0);
    idle(10);
    check("two_rows_no_issue", 64'(busy), 64'd0);
    rand_row(1'b0);
    drain("tile_after_reset");
    for (int t = 0; t < 9; t++) write_w(t, $urandom, 1'b0);

    // frame_start after 2 rows restarts the load
    rand_row(1'b0);
    rand_row(1'b0);
    pulse_fs();
    rand_row(1'b0);
    rand_row(1'b0);
    idle(5);
    check("fs_restart_not_busy", 64'(busy), 64'd0);
    rand_row(1'b0);
    drain("tile_after_fs");

    // frame_start together with a row
    rand_row(1'b1);
    rand_row(1'b0);
    rand_row(1'b0);
    drain("tile_fs_with_row");

    // single row after a full tile (slides the window when reuse is built in)
    for (int k = 0; k < 3; k++) rand_row(1'b0);
    drain("tile_abc");
    rand_row(1'b0);
    drain("tile_single_row");
    pulse_fs();
    rand_row(1'b0);
    idle(5);
    check("fs_needs_three", 64'(busy), 64'd0);
    rand_row(1'b0);
    rand_row(1'b0);
    drain("tile_after_fs_reuse");

    // randomized traffic
    or_mode = 3;
    for (int n = 0; n < 60; n++) begin
      act = $urandom_range(0, 9);
      if (act == 0) begin
        pulse_fs();
      end else if (act == 1) begin
        drain("rand_before_wr");
        write_w($urandom_range(0, 11), $urandom, 1'b0);
      end else begin
        rand_row(1'b0);
      end
    end
    or_mode = 1;
    drain("rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
